// File: rtl/bp_pkg.sv
// Shared types for the RAT fetch-stage branch predictor: 2-bit counter
// encoding, its post-reset value, and the init/run controller states.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bp_cnt_t;

  localparam bp_cnt_t BP_CNT_INIT = WEAK_T;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

endpackage

// File: rtl/bp_cnt_next.sv
// Saturating 2-bit counter step: moves one state toward taken or not-taken
// and holds at either end, never wrapping.
module bp_cnt_next
  import bp_pkg::*;
(
  input  bp_cnt_t i_cnt,
  input  logic    i_taken,
  output bp_cnt_t o_cnt
);

  // Next-count selection for the trained entry
  always_comb begin
    o_cnt = i_cnt;
    case (i_cnt)
      STRONG_NT: o_cnt = i_taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   o_cnt = i_taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    o_cnt = i_taken ? STRONG_T : WEAK_NT;
      STRONG_T:  o_cnt = i_taken ? STRONG_T : WEAK_T;
      default:   o_cnt = BP_CNT_INIT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Pattern history table of 2-bit counters with a post-reset init sweep.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int PC_BITS  = 10
) (
  input  logic                BP_CLK,
  input  logic                BP_RST,
  input  logic                BP_LOOKUP,
  input  logic [PC_BITS-1:0]  BP_PC_IN,
  output logic                BP_PRED_VALID,
  output logic                BP_PRED_TAKEN,
  output logic [IDX_BITS-1:0] BP_PRED_IDX,
  input  logic                BP_UPD_VALID,
  input  logic [IDX_BITS-1:0] BP_UPD_IDX,
  input  logic                BP_UPD_TAKEN,
  output logic                BP_READY
);

  localparam int ENTRIES = 1 << IDX_BITS;

  bp_cnt_t             r_table [ENTRIES];
  bp_state_t           r_state;
  logic [IDX_BITS-1:0] r_ptr;
  logic                r_ready;
  logic                r_pred_valid;
  logic                r_pred_taken;
  logic [IDX_BITS-1:0] r_pred_idx;

  logic [IDX_BITS-1:0] w_lookup_idx;
  bp_cnt_t             w_lookup_cnt;
  logic                w_lookup_taken;
  bp_cnt_t             w_upd_cur;
  bp_cnt_t             w_upd_next;
  logic                w_unused_pc;

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;
  assign w_lookup_idx = BP_PC_IN[IDX_BITS-1:0] ^ r_ghr;
`else
  assign w_lookup_idx = BP_PC_IN[IDX_BITS-1:0];
`endif

  assign w_unused_pc    = ^BP_PC_IN[PC_BITS-1:IDX_BITS];
  assign w_lookup_cnt   = r_table[w_lookup_idx];
  assign w_lookup_taken = (w_lookup_cnt == WEAK_T) || (w_lookup_cnt == STRONG_T);
  assign w_upd_cur      = r_table[BP_UPD_IDX];

  bp_cnt_next u_cnt_next (
    .i_cnt   (w_upd_cur),
    .i_taken (BP_UPD_TAKEN),
    .o_cnt   (w_upd_next)
  );

  // Single write port: sweep writes in INIT, training writes in RUN
  always_ff @(posedge BP_CLK) begin
    if (r_state == INIT) begin
      r_table[r_ptr] <= BP_CNT_INIT;
    end else if (BP_UPD_VALID) begin
      r_table[BP_UPD_IDX] <= w_upd_next;
    end
  end

  // Controller: init sweep, then registered predictions and history
  always_ff @(posedge BP_CLK) begin
    if (BP_RST) begin
      r_state      <= INIT;
      r_ptr        <= {IDX_BITS{1'b0}};
      r_ready      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= {IDX_BITS{1'b0}};
`ifdef BP_GSHARE_EN
      r_ghr        <= {IDX_BITS{1'b0}};
`endif
    end else begin
      case (r_state)
        INIT: begin
          r_pred_valid <= 1'b0;
          if (r_ptr == {IDX_BITS{1'b1}}) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + {{(IDX_BITS-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          r_pred_valid <= BP_LOOKUP;
          if (BP_LOOKUP) begin
            r_pred_taken <= w_lookup_taken;
            r_pred_idx   <= w_lookup_idx;
          end
`ifdef BP_GSHARE_EN
          if (BP_UPD_VALID) begin
            r_ghr <= {r_ghr[IDX_BITS-2:0], BP_UPD_TAKEN};
          end
`endif
        end
        default: begin
          r_state <= INIT;
          r_ptr   <= {IDX_BITS{1'b0}};
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign BP_PRED_VALID = r_pred_valid;
  assign BP_PRED_TAKEN = r_pred_taken;
  assign BP_PRED_IDX   = r_pred_idx;
  assign BP_READY      = r_ready;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset
// sequences and randomized traffic checked against a counter-array model.
module tb_branch_predictor;

  localparam int IDX_BITS = 5;
  localparam int PC_BITS  = 10;
  localparam int N        = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                lookup = 1'b0;
  logic [PC_BITS-1:0]  pc = '0;
  logic                upd_valid = 1'b0;
  logic [IDX_BITS-1:0] upd_idx = '0;
  logic                upd_taken = 1'b0;
  logic                pred_valid, pred_taken, ready;
  logic [IDX_BITS-1:0] pred_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt[N];
  int m_ghr;

  typedef struct {
    logic lk; int pc; logic uv; int ui; logic ut;
    logic ev; logic et; int ei;
  } vec_t;

  vec_t vecs[19];

  branch_predictor #(.IDX_BITS(IDX_BITS), .PC_BITS(PC_BITS)) dut (
    .BP_CLK        (clk),
    .BP_RST        (rst),
    .BP_LOOKUP     (lookup),
    .BP_PC_IN      (pc),
    .BP_PRED_VALID (pred_valid),
    .BP_PRED_TAKEN (pred_taken),
    .BP_PRED_IDX   (pred_idx),
    .BP_UPD_VALID  (upd_valid),
    .BP_UPD_IDX    (upd_idx),
    .BP_UPD_TAKEN  (upd_taken),
    .BP_READY      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lk, input int p, input logic uv, input int ui, input logic ut);
    lookup    = lk;
    pc        = PC_BITS'(p);
    upd_valid = uv;
    upd_idx   = IDX_BITS'(ui);
    upd_taken = ut;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 2;
    m_ghr = 0;
  endtask

  function automatic int model_idx(input int p);
`ifdef BP_GSHARE_EN
    return (p % N) ^ m_ghr;
`else
    return p % N;
`endif
  endfunction

  task automatic model_update(input int i, input logic t);
    if (t) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
    else   m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
    m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) % N;
  endtask

  // Reset for one cycle, then watch the 32-cycle sweep with traffic that must be dropped
  task automatic reset_and_sweep();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", pred_valid, 1'b0);
    chk("rst_taken", pred_taken, 1'b0);
    chk("rst_idx", pred_idx, 0);
    for (int k = 0; k < N; k++) begin
      chk("init_ready_low", ready, 1'b0);
      drive(k == 10, 10, k == 12, 10, 1'b0);
      tick();
      chk("init_no_pred", pred_valid, 1'b0);
    end
    chk("ready_at_32", ready, 1'b1);
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    model_reset();
  endtask

  initial begin
    vecs = '{
      '{1'b1, 'h00A, 1'b0,  0, 1'b0, 1'b1, 1'b1, 10},
      '{1'b0, 0,     1'b1, 10, 1'b0, 1'b0, 1'b0,  0},
      '{1'b1, 'h00A, 1'b1, 10, 1'b0, 1'b1, 1'b0, 10},
      '{1'b0, 0,     1'b1, 10, 1'b0, 1'b0, 1'b0,  0},
      '{1'b1, 'h00A, 1'b0,  0, 1'b0, 1'b1, 1'b0, 10},
      '{1'b0, 0,     1'b1, 10, 1'b1, 1'b0, 1'b0,  0},
      '{1'b1, 'h00A, 1'b1, 10, 1'b1, 1'b1, 1'b0, 10},
      '{1'b1, 'h00A, 1'b1, 10, 1'b1, 1'b1, 1'b1, 10},
      '{1'b0, 0,     1'b1, 10, 1'b1, 1'b0, 1'b0,  0},
      '{1'b0, 0,     1'b1, 10, 1'b0, 1'b0, 1'b0,  0},
      '{1'b1, 'h00A, 1'b0,  0, 1'b0, 1'b1, 1'b1, 10},
      '{1'b1, 'h005, 1'b1,  5, 1'b0, 1'b1, 1'b1,  5},
      '{1'b1, 'h005, 1'b0,  0, 1'b0, 1'b1, 1'b0,  5},
      '{1'b0, 0,     1'b1,  7, 1'b1, 1'b0, 1'b0,  0},
      '{1'b0, 0,     1'b1,  7, 1'b0, 1'b0, 1'b0,  0},
      '{1'b0, 0,     1'b1,  7, 1'b0, 1'b0, 1'b0,  0},
      '{1'b1, 'h007, 1'b0,  0, 1'b0, 1'b1, 1'b0,  7},
      '{1'b1, 'h3E3, 1'b0,  0, 1'b0, 1'b1, 1'b1,  3},
      '{1'b0, 0,     1'b0,  0, 1'b0, 1'b0, 1'b0,  0}
    };

    tick();
    reset_and_sweep();

`ifndef BP_GSHARE_EN
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].lk, vecs[v].pc, vecs[v].uv, vecs[v].ui, vecs[v].ut);
      tick();
      chk($sformatf("vec%0d_valid", v), pred_valid, vecs[v].ev);
      if (vecs[v].ev) begin
        chk($sformatf("vec%0d_taken", v), pred_taken, vecs[v].et);
        chk($sformatf("vec%0d_idx", v), pred_idx, vecs[v].ei);
      end
    end

    // Train idx 3 to strong-NT, then reset mid-RUN and confirm it is back to weak-T
    drive(1'b0, 0, 1'b1, 3, 1'b0); tick();
    drive(1'b0, 0, 1'b1, 3, 1'b0); tick();
    drive(1'b1, 3, 1'b0, 0, 1'b0); tick();
    chk("trained3_taken", pred_taken, 1'b0);
    drive(1'b1, 9, 1'b0, 0, 1'b0); tick();
    chk("pre_rst_idx9", pred_idx, 9);
    reset_and_sweep();
    drive(1'b1, 3, 1'b0, 0, 1'b0); tick();
    chk("post_rst3_valid", pred_valid, 1'b1);
    chk("post_rst3_taken", pred_taken, 1'b1);
    chk("post_rst3_idx", pred_idx, 3);
`else
    drive(1'b0, 0, 1'b1, 1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1, 1'b1); tick();
    drive(1'b1, 1, 1'b0, 0, 1'b0); tick();
    chk("gshare_valid", pred_valid, 1'b1);
    chk("gshare_idx", pred_idx, 2);
    chk("gshare_taken", pred_taken, 1'b1);
    reset_and_sweep();
`endif

    // Randomized traffic against the model; narrow update range forces collisions
    for (int c = 0; c < 400; c++) begin
      logic lk, uv, ut, et;
      int p, ui, ei;
      lk = 1'($urandom_range(0, 1));
      p  = $urandom_range(0, 1023);
      uv = 1'($urandom_range(0, 1));
      ui = $urandom_range(0, 7);
      ut = 1'($urandom_range(0, 1));
      ei = model_idx(p);
      et = (m_cnt[ei] >= 2);
      if (uv) model_update(ui, ut);
      drive(lk, p, uv, ui, ut);
      tick();
      chk("rand_valid", pred_valid, lk);
      if (lk) begin
        chk("rand_taken", pred_taken, et);
        chk("rand_idx", pred_idx, ei);
      end
    end

    drive(1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
